// File: rtl/store_formatter_if.sv
// store_formatter_if: store request, memory write and error signals of the store formatter
interface store_formatter_if #(parameter int AW = 32);
  logic req_valid;
  logic req_ready;
  logic [1:0] req_type;
  logic [AW-1:0] req_addr;
  logic [31:0] req_data;
  logic mem_we;
  logic [AW-1:0] mem_addr;
  logic [3:0] mem_be;
  logic [31:0] mem_wdata;
  logic mem_ack;
  logic err_valid;
  logic [AW-1:0] err_addr;
  logic busy;
  modport master (
    input req_valid, req_type, req_addr, req_data, mem_ack,
    output req_ready, mem_we, mem_addr, mem_be, mem_wdata, err_valid, err_addr, busy
  );
  modport slave (
    output req_valid, req_type, req_addr, req_data, mem_ack,
    input req_ready, mem_we, mem_addr, mem_be, mem_wdata, err_valid, err_addr, busy
  );
endinterface

// File: rtl/store_formatter.sv
// store_formatter: formats SB/SH/SW stores onto byte lanes, queues them and drives the memory write handshake
module store_formatter #(
  parameter int DEPTH = 2,
  parameter int AW = 32
) (
  input logic clk,
  input logic rst,
  store_formatter_if.master bus
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [0:0] IDLE = 1'b0, WRITE = 1'b1;
  typedef struct packed {
    logic [AW-1:0] addr;
    logic [3:0] be;
    logic [31:0] wdata;
  } entry_t;
  entry_t fifo [DEPTH];
  entry_t in_e, src;
  logic [PW-1:0] rd, wr, rd_n;
  logic [PW:0] count;
  logic [0:0] state;
  logic [1:0] off;
  logic legal, acc, push, pop, load;
  always_comb begin
    off = bus.req_addr[1:0];
    legal = bus.req_type == 2'b00 || (bus.req_type == 2'b01 && !off[0]) || (bus.req_type == 2'b10 && off == 2'b00);
    in_e.addr = {bus.req_addr[AW-1:2], 2'b00};
    in_e.be = bus.req_type == 2'b00 ? 4'b0001 << off : bus.req_type == 2'b01 ? (off[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    in_e.wdata = bus.req_type == 2'b00 ? {4{bus.req_data[7:0]}} : bus.req_type == 2'b01 ? {2{bus.req_data[15:0]}} : bus.req_data;
  end
  assign bus.req_ready = count != (PW+1)'(DEPTH);
  assign bus.mem_we = state;
  assign bus.busy = count != '0 || state == WRITE;
  assign acc = bus.req_valid && bus.req_ready;
  assign push = acc && legal;
  assign pop = state == WRITE && bus.mem_ack;
  assign rd_n = rd + 1'b1;
  // The head entry is the one on the bus; an empty FIFO forwards the incoming entry so writes start one cycle after acceptance.
  assign load = state == IDLE ? (count != '0 || push) : (pop && (count > (PW+1)'(1) || push));
  assign src = state == IDLE ? (count != '0 ? fifo[rd] : in_e) : (count > (PW+1)'(1) ? fifo[rd_n] : in_e);
  always_ff @(posedge clk)
    if (push) fifo[wr] <= in_e;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      rd <= '0;
      wr <= '0;
      count <= '0;
      bus.mem_addr <= '0;
      bus.mem_be <= '0;
      bus.mem_wdata <= '0;
      bus.err_valid <= 1'b0;
      bus.err_addr <= '0;
    end else begin
      state <= load ? WRITE : pop ? IDLE : state;
      if (push) wr <= wr + 1'b1;
      if (pop) rd <= rd_n;
      count <= count + (PW+1)'(push) - (PW+1)'(pop);
      if (load) begin
        bus.mem_addr <= src.addr;
        bus.mem_be <= src.be;
        bus.mem_wdata <= src.wdata;
      end
      bus.err_valid <= acc && !legal;
      if (acc && !legal) bus.err_addr <= bus.req_addr;
    end
endmodule
